// File: rtl/rat_multi.sv
// Multi-lane register alias table: same-cycle lookup with intra-group bypass, CDB wakeup and flush recovery from the retirement RAT.
// Optional checkpoint save/restore is compiled in when RAT_CHECKPOINT_EN is defined.
module rat_multi #(
    parameter int NUM_ARCH  = 32,
    parameter int NUM_PHYS  = 64,
    parameter int RENAME_W  = 2,
    parameter int CDB_PORTS = 2,
    localparam int AW = $clog2(NUM_ARCH),
    localparam int PW = $clog2(NUM_PHYS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RENAME_W-1:0]       ren_valid,
    input  logic [RENAME_W-1:0]       ren_we,
    input  logic [RENAME_W*AW-1:0]    ren_rs1,
    input  logic [RENAME_W*AW-1:0]    ren_rs2,
    input  logic [RENAME_W*AW-1:0]    ren_rd,
    input  logic [RENAME_W*PW-1:0]    ren_pd,
    output logic [RENAME_W*PW-1:0]    ren_ps1,
    output logic [RENAME_W*PW-1:0]    ren_ps2,
    output logic [RENAME_W-1:0]       ren_ps1_rdy,
    output logic [RENAME_W-1:0]       ren_ps2_rdy,
    output logic [RENAME_W*PW-1:0]    ren_old_pd,
    input  logic [CDB_PORTS-1:0]      cdb_valid,
    input  logic [CDB_PORTS*AW-1:0]   cdb_rd,
    input  logic [CDB_PORTS*PW-1:0]   cdb_pd,
    input  logic                      flush,
`ifdef RAT_CHECKPOINT_EN
    input  logic                      ckpt_save,
    input  logic                      ckpt_restore,
    output logic                      ckpt_valid,
`endif
    input  logic [NUM_ARCH*PW-1:0]    rrat_map,
    input  logic                      commit_valid,
    input  logic [AW-1:0]             commit_rd,
    input  logic [PW-1:0]             commit_pd
);

    logic [PW-1:0]       map_q [NUM_ARCH];
    logic [PW-1:0]       map_d [NUM_ARCH];
    logic [NUM_ARCH-1:0] rdy_q;
    logic [NUM_ARCH-1:0] rdy_d;
    logic [NUM_ARCH-1:0] cdb_wake;

    // A broadcast only wakes an entry whose current mapping matches its tag; stale tags are dropped.
    always_comb begin
        cdb_wake = '0;
        for (int a = 1; a < NUM_ARCH; a++) begin
            for (int k = 0; k < CDB_PORTS; k++) begin
                if (cdb_valid[k] && cdb_rd[k*AW +: AW] == AW'(a) &&
                    cdb_pd[k*PW +: PW] == map_q[a]) begin
                    cdb_wake[a] = 1'b1;
                end
            end
        end
    end

    for (genvar j = 0; j < RENAME_W; j++) begin : g_lane
        logic [AW-1:0] rs1, rs2, rd;
        logic [PW-1:0] ps1, ps2, opd;
        logic          r1, r2;

        assign rs1 = ren_rs1[j*AW +: AW];
        assign rs2 = ren_rs2[j*AW +: AW];
        assign rd  = ren_rd[j*AW +: AW];

        // Older lanes are scanned in ascending order so the youngest matching writer ends up winning.
        always_comb begin
            ps1 = map_q[rs1];
            r1  = rdy_q[rs1] | cdb_wake[rs1];
            ps2 = map_q[rs2];
            r2  = rdy_q[rs2] | cdb_wake[rs2];
            opd = map_q[rd];
            for (int i = 0; i < j; i++) begin
                if (ren_valid[i] && ren_we[i]) begin
                    if (ren_rd[i*AW +: AW] == rs1) begin
                        ps1 = ren_pd[i*PW +: PW];
                        r1  = 1'b0;
                    end
                    if (ren_rd[i*AW +: AW] == rs2) begin
                        ps2 = ren_pd[i*PW +: PW];
                        r2  = 1'b0;
                    end
                    if (ren_rd[i*AW +: AW] == rd) begin
                        opd = ren_pd[i*PW +: PW];
                    end
                end
            end
            if (rs1 == '0) begin
                ps1 = '0;
                r1  = 1'b1;
            end
            if (rs2 == '0) begin
                ps2 = '0;
                r2  = 1'b1;
            end
            if (rd == '0) begin
                opd = '0;
            end
        end

        assign ren_ps1[j*PW +: PW]    = ps1;
        assign ren_ps2[j*PW +: PW]    = ps2;
        assign ren_ps1_rdy[j]         = r1;
        assign ren_ps2_rdy[j]         = r2;
        assign ren_old_pd[j*PW +: PW] = opd;
    end

`ifdef RAT_CHECKPOINT_EN
    logic [PW-1:0]       ckpt_map_q [NUM_ARCH];
    logic [PW-1:0]       ckpt_map_d [NUM_ARCH];
    logic [NUM_ARCH-1:0] ckpt_rdy_q;
    logic [NUM_ARCH-1:0] ckpt_rdy_d;
    logic                ckpt_valid_q;
    logic                ckpt_valid_d;
    logic [NUM_ARCH-1:0] ckpt_wake;

    // Snapshot wakeups match against the snapshot's own mappings.
    always_comb begin
        ckpt_wake = '0;
        for (int a = 1; a < NUM_ARCH; a++) begin
            for (int k = 0; k < CDB_PORTS; k++) begin
                if (cdb_valid[k] && cdb_rd[k*AW +: AW] == AW'(a) &&
                    cdb_pd[k*PW +: PW] == ckpt_map_q[a]) begin
                    ckpt_wake[a] = 1'b1;
                end
            end
        end
    end

    assign ckpt_valid = ckpt_valid_q;
`endif

    // Priority from lowest to highest: CDB wakeup, rename, checkpoint restore, flush; entry 0 is pinned last.
    always_comb begin
        map_d = map_q;
        rdy_d = rdy_q | cdb_wake;
        for (int i = 0; i < RENAME_W; i++) begin
            if (ren_valid[i] && ren_we[i] && ren_rd[i*AW +: AW] != '0) begin
                map_d[ren_rd[i*AW +: AW]] = ren_pd[i*PW +: PW];
                rdy_d[ren_rd[i*AW +: AW]] = 1'b0;
            end
        end
`ifdef RAT_CHECKPOINT_EN
        ckpt_map_d   = ckpt_map_q;
        ckpt_rdy_d   = ckpt_valid_q ? (ckpt_rdy_q | ckpt_wake) : ckpt_rdy_q;
        ckpt_valid_d = ckpt_valid_q;
        if (ckpt_restore && ckpt_valid_q) begin
            map_d        = ckpt_map_q;
            rdy_d        = ckpt_rdy_q | ckpt_wake;
            ckpt_valid_d = 1'b0;
        end
`endif
        if (flush) begin
            for (int a = 0; a < NUM_ARCH; a++) begin
                map_d[a] = rrat_map[a*PW +: PW];
            end
            rdy_d = '1;
            if (commit_valid) begin
                map_d[commit_rd] = commit_pd;
            end
        end
        map_d[0] = '0;
        rdy_d[0] = 1'b1;
`ifdef RAT_CHECKPOINT_EN
        if (flush) begin
            ckpt_valid_d = 1'b0;
        end else if (ckpt_save && !(ckpt_restore && ckpt_valid_q)) begin
            ckpt_map_d   = map_d;
            ckpt_rdy_d   = rdy_d;
            ckpt_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_ARCH; a++) begin
                map_q[a] <= PW'(a);
            end
            rdy_q <= '1;
        end else begin
            map_q <= map_d;
            rdy_q <= rdy_d;
        end
    end

`ifdef RAT_CHECKPOINT_EN
    // Snapshot contents are qualified by ckpt_valid_q, so only the valid bit is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ckpt_valid_q <= 1'b0;
        end else begin
            ckpt_valid_q <= ckpt_valid_d;
        end
        ckpt_map_q <= ckpt_map_d;
        ckpt_rdy_q <= ckpt_rdy_d;
    end
`endif

endmodule

// File: tb/tb_rat_multi.sv
// Self-checking bench for rat_multi: directed scenarios plus randomized traffic against an array-based reference model.
module tb_rat_multi;
    localparam int NA = 32;
    localparam int NP = 64;
    localparam int RW = 2;
    localparam int CP = 2;
    localparam int AW = 5;
    localparam int PW = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [RW-1:0]     ren_valid, ren_we;
    logic [RW*AW-1:0]  ren_rs1, ren_rs2, ren_rd;
    logic [RW*PW-1:0]  ren_pd, ren_ps1, ren_ps2, ren_old_pd;
    logic [RW-1:0]     ren_ps1_rdy, ren_ps2_rdy;
    logic [CP-1:0]     cdb_valid;
    logic [CP*AW-1:0]  cdb_rd;
    logic [CP*PW-1:0]  cdb_pd;
    logic              flush;
    logic [NA*PW-1:0]  rrat_map;
    logic              commit_valid;
    logic [AW-1:0]     commit_rd;
    logic [PW-1:0]     commit_pd;
`ifdef RAT_CHECKPOINT_EN
    logic              ckpt_valid;
`endif

    rat_multi #(.NUM_ARCH(NA), .NUM_PHYS(NP), .RENAME_W(RW), .CDB_PORTS(CP)) dut (
        .clk(clk), .rst(rst),
        .ren_valid(ren_valid), .ren_we(ren_we),
        .ren_rs1(ren_rs1), .ren_rs2(ren_rs2), .ren_rd(ren_rd), .ren_pd(ren_pd),
        .ren_ps1(ren_ps1), .ren_ps2(ren_ps2),
        .ren_ps1_rdy(ren_ps1_rdy), .ren_ps2_rdy(ren_ps2_rdy),
        .ren_old_pd(ren_old_pd),
        .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_pd(cdb_pd),
        .flush(flush),
`ifdef RAT_CHECKPOINT_EN
        .ckpt_save(1'b0), .ckpt_restore(1'b0), .ckpt_valid(ckpt_valid),
`endif
        .rrat_map(rrat_map),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_pd(commit_pd)
    );

    always #5 clk = ~clk;

    // Stimulus for the current cycle.
    bit t_v[RW], t_we[RW];
    int t_rs1[RW], t_rs2[RW], t_rd[RW], t_pd[RW];
    bit c_v[CP];
    int c_rd[CP], c_pd[CP];
    bit f_flush;
    int rrat[NA];
    bit cm_v;
    int cm_rd, cm_pd;

    // Reference architectural state.
    int m_map[NA];
    bit m_rdy[NA];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int j = 0; j < RW; j++) begin
            t_v[j] = 0; t_we[j] = 0; t_rs1[j] = 0; t_rs2[j] = 0; t_rd[j] = 0; t_pd[j] = 0;
        end
        for (int k = 0; k < CP; k++) begin
            c_v[k] = 0; c_rd[k] = 0; c_pd[k] = 0;
        end
        f_flush = 0; cm_v = 0; cm_rd = 0; cm_pd = 0;
    endtask

    task automatic drive();
        for (int j = 0; j < RW; j++) begin
            ren_valid[j]         = t_v[j];
            ren_we[j]            = t_we[j];
            ren_rs1[j*AW +: AW]  = AW'(t_rs1[j]);
            ren_rs2[j*AW +: AW]  = AW'(t_rs2[j]);
            ren_rd[j*AW +: AW]   = AW'(t_rd[j]);
            ren_pd[j*PW +: PW]   = PW'(t_pd[j]);
        end
        for (int k = 0; k < CP; k++) begin
            cdb_valid[k]         = c_v[k];
            cdb_rd[k*AW +: AW]   = AW'(c_rd[k]);
            cdb_pd[k*PW +: PW]   = PW'(c_pd[k]);
        end
        for (int a = 0; a < NA; a++) rrat_map[a*PW +: PW] = PW'(rrat[a]);
        flush        = f_flush;
        commit_valid = cm_v;
        commit_rd    = AW'(cm_rd);
        commit_pd    = PW'(cm_pd);
    endtask

    // What lane `lane` should see for architectural register rs this cycle.
    task automatic ref_lookup(input int lane, input int rs, output int ps, output bit r);
        if (rs == 0) begin
            ps = 0; r = 1; return;
        end
        for (int i = lane - 1; i >= 0; i--) begin
            if (t_v[i] && t_we[i] && t_rd[i] == rs) begin
                ps = t_pd[i]; r = 0; return;
            end
        end
        ps = m_map[rs];
        r  = m_rdy[rs];
        for (int k = 0; k < CP; k++)
            if (c_v[k] && c_rd[k] == rs && c_pd[k] == m_map[rs]) r = 1;
    endtask

    task automatic compare_model();
        int ps;
        bit r;
        if (f_flush) return;
        for (int j = 0; j < RW; j++) begin
            if (t_v[j]) begin
                ref_lookup(j, t_rs1[j], ps, r);
                check($sformatf("ps1[%0d] rs=%0d", j, t_rs1[j]), ren_ps1[j*PW +: PW], ps);
                check($sformatf("ps1_rdy[%0d] rs=%0d", j, t_rs1[j]), ren_ps1_rdy[j], r);
                ref_lookup(j, t_rs2[j], ps, r);
                check($sformatf("ps2[%0d] rs=%0d", j, t_rs2[j]), ren_ps2[j*PW +: PW], ps);
                check($sformatf("ps2_rdy[%0d] rs=%0d", j, t_rs2[j]), ren_ps2_rdy[j], r);
                ref_lookup(j, t_rd[j], ps, r);
                check($sformatf("old_pd[%0d] rd=%0d", j, t_rd[j]), ren_old_pd[j*PW +: PW], ps);
            end
        end
    endtask

    task automatic update_model();
        bit wake[NA];
        bit renamed[NA];
        if (f_flush) begin
            for (int a = 0; a < NA; a++) begin
                m_map[a] = (a == 0) ? 0 : rrat[a];
                m_rdy[a] = 1;
            end
            if (cm_v && cm_rd != 0) m_map[cm_rd] = cm_pd;
            return;
        end
        for (int a = 0; a < NA; a++) begin
            wake[a] = 0; renamed[a] = 0;
        end
        for (int k = 0; k < CP; k++)
            if (c_v[k] && c_rd[k] != 0 && c_pd[k] == m_map[c_rd[k]]) wake[c_rd[k]] = 1;
        for (int i = 0; i < RW; i++) begin
            if (t_v[i] && t_we[i] && t_rd[i] != 0) begin
                m_map[t_rd[i]] = t_pd[i];
                renamed[t_rd[i]] = 1;
            end
        end
        for (int a = 0; a < NA; a++) begin
            if (renamed[a]) m_rdy[a] = 0;
            else if (wake[a]) m_rdy[a] = 1;
        end
    endtask

    task automatic apply();
        drive();
        #2;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        update_model();
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        for (int a = 0; a < NA; a++) rrat[a] = a;
        clear_inputs();
        drive();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        for (int a = 0; a < NA; a++) begin
            m_map[a] = a; m_rdy[a] = 1;
        end
        @(negedge clk);
        rst = 1'b0;

        // Reset state: every register maps to itself and is ready.
        for (int c = 0; c < NA / 2; c++) begin
            t_v[0] = 1; t_rs1[0] = 2 * c; t_rs2[0] = 2 * c + 1; t_rd[0] = 2 * c;
            apply();
            check("rst_map_even", ren_ps1[0 +: PW], 2 * c);
            check("rst_map_odd", ren_ps2[0 +: PW], 2 * c + 1);
            check("rst_rdy_odd", ren_ps2_rdy[0], 1);
            tick();
        end

        t_v[0] = 1; t_rs1[0] = 5; t_rs2[0] = 0;
        apply();
        check("tp1_ps1", ren_ps1[0 +: PW], 5);
        check("tp1_rdy1", ren_ps1_rdy[0], 1);
        check("tp1_ps2", ren_ps2[0 +: PW], 0);
        check("tp1_rdy2", ren_ps2_rdy[0], 1);
        tick();

        t_v[0] = 1; t_we[0] = 1; t_rd[0] = 3; t_pd[0] = 40;
        t_v[1] = 1; t_rs1[1] = 3;
        apply();
        check("tp2_bypass_ps", ren_ps1[PW +: PW], 40);
        check("tp2_bypass_rdy", ren_ps1_rdy[1], 0);
        check("tp2_old_pd0", ren_old_pd[0 +: PW], 3);
        tick();

        t_v[0] = 1; t_rs1[0] = 3;
        apply();
        check("tp2_map3", ren_ps1[0 +: PW], 40);
        check("tp2_rdy3", ren_ps1_rdy[0], 0);
        tick();

        t_v[0] = 1; t_we[0] = 1; t_rd[0] = 7; t_pd[0] = 41;
        t_v[1] = 1; t_we[1] = 1; t_rd[1] = 7; t_pd[1] = 42;
        apply();
        check("tp3_old_pd1", ren_old_pd[PW +: PW], 41);
        tick();

        t_v[0] = 1; t_rs1[0] = 7;
        c_v[0] = 1; c_rd[0] = 7; c_pd[0] = 41;
        apply();
        check("tp4_map7", ren_ps1[0 +: PW], 42);
        check("tp4_stale_rdy", ren_ps1_rdy[0], 0);
        tick();

        t_v[0] = 1; t_rs1[0] = 7;
        c_v[1] = 1; c_rd[1] = 7; c_pd[1] = 42;
        apply();
        check("tp4_wake_same_cycle", ren_ps1_rdy[0], 1);
        tick();

        t_v[0] = 1; t_rs1[0] = 7;
        apply();
        check("tp4_wake_held", ren_ps1_rdy[0], 1);
        tick();

        t_v[0] = 1; t_we[0] = 1; t_rd[0] = 4; t_pd[0] = 50;
        t_v[1] = 1; t_rs1[1] = 4;
        c_v[0] = 1; c_rd[0] = 4; c_pd[0] = 4;
        apply();
        check("tp5_bypass_ps", ren_ps1[PW +: PW], 50);
        check("tp5_bypass_rdy", ren_ps1_rdy[1], 0);
        tick();

        t_v[0] = 1; t_rs1[0] = 4;
        apply();
        check("tp5_map4", ren_ps1[0 +: PW], 50);
        check("tp5_rename_beats_cdb", ren_ps1_rdy[0], 0);
        tick();

        for (int a = 0; a < NA; a++) rrat[a] = (a + 32) % NP;
        f_flush = 1; cm_v = 1; cm_rd = 9; cm_pd = 60;
        t_v[0] = 1; t_we[0] = 1; t_rd[0] = 1; t_pd[0] = 5;
        apply();
        tick();

        t_v[0] = 1; t_rs1[0] = 9; t_rs2[0] = 1;
        apply();
        check("tp6_map9", ren_ps1[0 +: PW], 60);
        check("tp6_rdy9", ren_ps1_rdy[0], 1);
        check("tp6_map1", ren_ps2[0 +: PW], 33);
        check("tp6_rdy1", ren_ps2_rdy[0], 1);
        tick();

        t_v[0] = 1; t_rs1[0] = 0; t_rs2[0] = 7;
        apply();
        check("tp6_map0", ren_ps1[0 +: PW], 0);
        check("tp6_map7", ren_ps2[0 +: PW], 39);
        check("tp6_rdy7", ren_ps2_rdy[0], 1);
        tick();

        // Random traffic over a narrow register window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            for (int j = 0; j < RW; j++) begin
                t_v[j]   = ($urandom_range(0, 3) != 0);
                t_we[j]  = $urandom_range(0, 1);
                t_rs1[j] = $urandom_range(0, 7);
                t_rs2[j] = $urandom_range(0, 7);
                t_rd[j]  = $urandom_range(0, 7);
                t_pd[j]  = $urandom_range(0, NP - 1);
            end
            for (int k = 0; k < CP; k++) begin
                c_v[k]  = $urandom_range(0, 1);
                c_rd[k] = $urandom_range(0, 7);
                c_pd[k] = ($urandom_range(0, 1) != 0) ? m_map[c_rd[k]] : $urandom_range(0, NP - 1);
            end
            f_flush = ($urandom_range(0, 31) == 0);
            if (f_flush) begin
                for (int a = 0; a < NA; a++) rrat[a] = $urandom_range(0, NP - 1);
                cm_v  = $urandom_range(0, 1);
                cm_rd = $urandom_range(0, 7);
                cm_pd = $urandom_range(0, NP - 1);
            end
            apply();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
